// File: rtl/multicycle_control_fsm.sv
// LEGv8 multi-cycle sequencer: one state per cycle; R/STUR 4, LDUR 5, CBZ/B 3 cycles.
// Stalls in FETCH/MEM_RD/MEM_WR until mem_ready; halts on bad opcode or memory timeout.
module multicycle_control_fsm #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [10:0]      opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             pc_src,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_to_loc,
   output logic             reg_write,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [3:0]       state,
   output logic             halted,
   output logic             illegal_op,
   output logic             bus_error,
   output logic [CNT_W-1:0] retired
);
   localparam int WAIT_W = $clog2(TIMEOUT);

   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC_R   = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_HALT     = 4'd10
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_src;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_to_loc;
      logic       reg_write;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
   } ctl_t;

   state_t            cur, nxt;
   ctl_t              ctl;
   logic [WAIT_W-1:0] wait_cnt;
   logic              timeout, retire, set_ill, set_bus, mem_state;

   always_ff @(posedge clk) begin
      if (!reset_n) cur <= S_FETCH;
      else          cur <= nxt;
   end

   always_comb begin
      nxt     = cur;
      ctl     = '0;
      retire  = 1'b0;
      set_ill = 1'b0;
      set_bus = 1'b0;
      timeout = (wait_cnt == WAIT_W'(TIMEOUT - 1)) && !mem_ready;
      case (cur)
         S_FETCH: begin
            ctl.mem_read  = 1'b1;
            ctl.alu_src_b = 2'd1;
            if (mem_ready) begin
               ctl.ir_write = 1'b1;
               ctl.pc_write = 1'b1;
               nxt          = S_DECODE;
            end else if (timeout) begin
               nxt     = S_HALT;
               set_bus = 1'b1;
            end
         end
         S_DECODE: begin
            ctl.alu_src_b = 2'd3;
            casez (opcode)
               OP_LDUR, OP_STUR:                 nxt = S_MEM_ADDR;
               OP_ADD, OP_SUB, OP_AND, OP_ORR:   nxt = S_EXEC_R;
               11'b10110100???:                  nxt = S_BRANCH;
               11'b000101?????:                  nxt = S_JUMP;
               default: begin
                  nxt     = S_HALT;
                  set_ill = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR: begin
            ctl.alu_src_a  = 1'b1;
            ctl.alu_src_b  = 2'd2;
            ctl.reg_to_loc = 1'b1;
            nxt = (opcode == OP_LDUR) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            ctl.mem_read = 1'b1;
            ctl.iord     = 1'b1;
            if (mem_ready) nxt = S_MEM_WB;
            else if (timeout) begin
               nxt     = S_HALT;
               set_bus = 1'b1;
            end
         end
         S_MEM_WB: begin
            ctl.reg_write  = 1'b1;
            ctl.mem_to_reg = 1'b1;
            nxt    = S_FETCH;
            retire = 1'b1;
         end
         S_MEM_WR: begin
            ctl.mem_write  = 1'b1;
            ctl.iord       = 1'b1;
            ctl.reg_to_loc = 1'b1;
            if (mem_ready) begin
               nxt    = S_FETCH;
               retire = 1'b1;
            end else if (timeout) begin
               nxt     = S_HALT;
               set_bus = 1'b1;
            end
         end
         S_EXEC_R: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_op    = 2'b10;
            nxt = S_R_WB;
         end
         S_R_WB: begin
            ctl.reg_write = 1'b1;
            nxt    = S_FETCH;
            retire = 1'b1;
         end
         S_BRANCH: begin
            ctl.reg_to_loc    = 1'b1;
            ctl.alu_src_a     = 1'b1;
            ctl.alu_op        = 2'b01;
            ctl.pc_write_cond = 1'b1;
            ctl.pc_src        = 1'b1;
            nxt    = S_FETCH;
            retire = 1'b1;
         end
         S_JUMP: begin
            ctl.pc_write = 1'b1;
            ctl.pc_src   = 1'b1;
            nxt    = S_FETCH;
            retire = 1'b1;
         end
         S_HALT:  nxt = S_HALT;
         default: nxt = S_HALT;
      endcase
   end

   assign mem_state = (cur == S_FETCH) || (cur == S_MEM_RD) || (cur == S_MEM_WR);

   // Any state change clears the counter, which covers entry to every waiting state.
   always_ff @(posedge clk) begin
      if (!reset_n)                     wait_cnt <= '0;
      else if (nxt != cur)              wait_cnt <= '0;
      else if (mem_state && !mem_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         illegal_op <= 1'b0;
         bus_error  <= 1'b0;
         retired    <= '0;
      end else begin
         if (set_ill) illegal_op <= 1'b1;
         if (set_bus) bus_error  <= 1'b1;
         if (retire)  retired    <= retired + CNT_W'(1);
      end
   end

   // Strobes are forced low while reset is held so pending requests are dropped at once.
   assign {pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
           reg_to_loc, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op}
          = reset_n ? ctl : '0;
   assign state  = cur;
   assign halted = (cur == S_HALT);
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Table vectors, hand-written corner sequences and random stimulus against a step-queue model.
`timescale 1ns/1ps
module tb_multicycle_control_fsm;
   localparam int TIMEOUT = 16;
   localparam logic [10:0] LDUR = 11'b11111000010, STUR = 11'b11111000000;
   localparam logic [10:0] ADD  = 11'b10001011000, SUB  = 11'b11001011000;
   localparam logic [10:0] ANDI = 11'b10001010000, ORR  = 11'b10101010000;
   localparam logic [10:0] CBZ  = 11'b10110100101, BR   = 11'b00010111111;
   localparam logic [10:0] BAD  = 11'b11111111111;

   // pw pwc src iord mr mw ir rtl rw m2r a b op
   localparam logic [14:0] C_FR  = 15'b1_0_0_0_1_0_1_0_0_0_0_01_00;
   localparam logic [14:0] C_FW  = 15'b0_0_0_0_1_0_0_0_0_0_0_01_00;
   localparam logic [14:0] C_DEC = 15'b0_0_0_0_0_0_0_0_0_0_0_11_00;
   localparam logic [14:0] C_MA  = 15'b0_0_0_0_0_0_0_1_0_0_1_10_00;
   localparam logic [14:0] C_MRD = 15'b0_0_0_1_1_0_0_0_0_0_0_00_00;
   localparam logic [14:0] C_MWB = 15'b0_0_0_0_0_0_0_0_1_1_0_00_00;
   localparam logic [14:0] C_MWR = 15'b0_0_0_1_0_1_0_1_0_0_0_00_00;
   localparam logic [14:0] C_EX  = 15'b0_0_0_0_0_0_0_0_0_0_1_00_10;
   localparam logic [14:0] C_RWB = 15'b0_0_0_0_0_0_0_0_1_0_0_00_00;
   localparam logic [14:0] C_BR  = 15'b0_1_1_0_0_0_0_1_0_0_1_00_01;
   localparam logic [14:0] C_JMP = 15'b1_0_1_0_0_0_0_0_0_0_0_00_00;
   localparam logic [14:0] C_NONE = 15'b0;

   logic        clk = 1'b0, reset_n = 1'b0, mem_ready = 1'b0;
   logic [10:0] opcode = 11'b0;
   logic        pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write;
   logic        reg_to_loc, reg_write, mem_to_reg, alu_src_a, halted, illegal_op, bus_error;
   logic [1:0]  alu_src_b, alu_op;
   logic [3:0]  state;
   logic [31:0] retired;
   logic [14:0] act_ctl;

   int vectors = 0, miscompares = 0;

   multicycle_control_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_to_loc(reg_to_loc), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
      .halted(halted), .illegal_op(illegal_op), .bus_error(bus_error), .retired(retired)
   );

   always #5 clk = ~clk;

   assign act_ctl = {pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
                     reg_to_loc, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op};

   typedef struct {
      logic [10:0] opc;
      logic        rdy;
      logic [3:0]  st;
      logic [14:0] ctl;
      int          ret;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic [10:0] opc, input logic rdy, input logic [3:0] est,
                       input logic [14:0] ectl, input int eret, input string nm);
      @(negedge clk);
      reset_n = 1'b1; opcode = opc; mem_ready = rdy;
      #1;
      chk({nm, " state"}, 64'(state), 64'(est));
      chk({nm, " ctl"}, 64'(act_ctl), 64'(ectl));
      chk({nm, " retired"}, 64'(retired), 64'(eret));
      @(posedge clk);
   endtask

   task automatic do_reset(input string nm);
      @(negedge clk);
      reset_n = 1'b0; mem_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({nm, " rst state"}, 64'(state), 64'd0);
      chk({nm, " rst ctl"}, 64'(act_ctl), 64'd0);
      chk({nm, " rst retired"}, 64'(retired), 64'd0);
      chk({nm, " rst flags"}, 64'({halted, illegal_op, bus_error}), 64'd0);
   endtask

   // Reference model: a queue of pending steps per instruction, identified by state number.
   int          mq[$];
   int          m_wait, m_ret;
   logic        m_ill, m_bus;

   function automatic logic [14:0] ctrl_of(input int st, input logic rdy);
      case (st)
         0: return rdy ? C_FR : C_FW;
         1: return C_DEC;  2: return C_MA;  3: return C_MRD; 4: return C_MWB;
         5: return C_MWR;  6: return C_EX;  7: return C_RWB; 8: return C_BR;
         9: return C_JMP;
         default: return C_NONE;
      endcase
   endfunction

   function automatic logic [10:0] pick_op();
      logic [10:0] r = 11'($urandom);
      case ($urandom_range(0, 15))
         0, 1:  return LDUR;
         2, 3:  return STUR;
         4, 5:  return ADD;
         6:     return SUB;
         7:     return ANDI;
         8:     return ORR;
         9, 10: return {8'b10110100, r[2:0]};
         11, 12: return {6'b000101, r[4:0]};
         13:    return BAD;
         default: return r;
      endcase
   endfunction

   task automatic model_retire();
      m_ret++;
      mq.push_back(0);
   endtask

   task automatic model_step(input logic rdy, input logic [10:0] opc);
      int cur = mq[0];
      if (cur == 0 || cur == 3 || cur == 5) begin
         if (rdy) begin
            void'(mq.pop_front());
            m_wait = 0;
            if (cur == 0) mq.push_back(1);
            else if (mq.size() == 0) model_retire();
         end else if (m_wait == TIMEOUT - 1) begin
            mq = '{10};
            m_bus = 1'b1;
         end else m_wait++;
      end else if (cur == 1) begin
         void'(mq.pop_front());
         casez (opc)
            LDUR:                  mq = '{2, 3, 4};
            STUR:                  mq = '{2, 5};
            ADD, SUB, ANDI, ORR:   mq = '{6, 7};
            11'b10110100???:       mq = '{8};
            11'b000101?????:       mq = '{9};
            default: begin
               mq = '{10};
               m_ill = 1'b1;
            end
         endcase
      end else if (cur != 10) begin
         void'(mq.pop_front());
         if (mq.size() == 0) model_retire();
      end
   endtask

   vec_t tbl[$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl = '{
         '{ADD, 1, 0, C_FR, 0}, '{ADD, 0, 1, C_DEC, 0}, '{ADD, 1, 6, C_EX, 0}, '{ADD, 1, 7, C_RWB, 0},
         '{LDUR, 1, 0, C_FR, 1}, '{LDUR, 1, 1, C_DEC, 1}, '{LDUR, 0, 2, C_MA, 1},
         '{LDUR, 0, 3, C_MRD, 1}, '{LDUR, 0, 3, C_MRD, 1}, '{LDUR, 0, 3, C_MRD, 1},
         '{LDUR, 1, 3, C_MRD, 1}, '{LDUR, 1, 4, C_MWB, 1},
         '{CBZ, 1, 0, C_FR, 2}, '{CBZ, 1, 1, C_DEC, 2}, '{CBZ, 1, 8, C_BR, 2},
         '{BR, 1, 0, C_FR, 3}, '{BR, 1, 1, C_DEC, 3}, '{BR, 0, 9, C_JMP, 3},
         '{STUR, 1, 0, C_FR, 4}, '{STUR, 1, 1, C_DEC, 4}, '{STUR, 1, 2, C_MA, 4},
         '{STUR, 0, 5, C_MWR, 4}, '{STUR, 1, 5, C_MWR, 4},
         '{SUB, 0, 0, C_FW, 5}
      };

      do_reset("init");
      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i].opc, tbl[i].rdy, tbl[i].st, tbl[i].ctl, tbl[i].ret, $sformatf("tbl%0d", i));

      // Illegal opcode: absorbing HALT, then reset clears everything.
      do_reset("ill");
      step(BAD, 1, 0, C_FR, 0, "ill fetch");
      step(BAD, 1, 1, C_DEC, 0, "ill decode");
      for (int i = 0; i < 20; i++) step(BAD, i[0], 10, C_NONE, 0, "ill halt");
      chk("ill flags", 64'({halted, illegal_op, bus_error}), 64'b110);
      do_reset("ill clr");

      // Fetch timeout after 16 cycles without ready.
      for (int i = 0; i < TIMEOUT; i++) step(ADD, 0, 0, C_FW, 0, "to wait");
      step(ADD, 1, 10, C_NONE, 0, "to halt");
      chk("to flags", 64'({halted, illegal_op, bus_error}), 64'b101);

      // Ready on the final allowed cycle completes normally.
      do_reset("to2");
      for (int i = 0; i < TIMEOUT - 1; i++) step(ADD, 0, 0, C_FW, 0, "to2 wait");
      step(ADD, 1, 0, C_FR, 0, "to2 ready");
      step(ADD, 1, 1, C_DEC, 0, "to2 decode");
      chk("to2 bus_error", 64'(bus_error), 64'd0);
      step(ADD, 1, 6, C_EX, 0, "to2 exec");
      step(ADD, 1, 7, C_RWB, 0, "to2 rwb");

      // Reset during a store wait drops the write.
      step(STUR, 1, 0, C_FR, 1, "rw fetch");
      step(STUR, 1, 1, C_DEC, 1, "rw decode");
      step(STUR, 1, 2, C_MA, 1, "rw addr");
      step(STUR, 0, 5, C_MWR, 1, "rw wait");
      do_reset("rw");
      step(STUR, 0, 0, C_FW, 0, "rw after");

      // Random stimulus against the model.
      do_reset("rand");
      mq = '{0}; m_wait = 0; m_ret = 0; m_ill = 1'b0; m_bus = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         logic rst;
         @(negedge clk);
         rst = (mq[0] == 10) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 299) == 0);
         reset_n   = !rst;
         mem_ready = ($urandom_range(0, 9) < 7);
         if (mq[0] == 0 && !rst) opcode = pick_op();
         #1;
         chk("rnd state", 64'(state), 64'(mq[0]));
         chk("rnd ctl", 64'(act_ctl), 64'(rst ? C_NONE : ctrl_of(mq[0], mem_ready)));
         chk("rnd retired", 64'(retired), 64'(m_ret));
         chk("rnd flags", 64'({halted, illegal_op, bus_error}),
             64'({(mq[0] == 10), m_ill, m_bus}));
         if (rst) begin
            mq = '{0}; m_wait = 0; m_ret = 0; m_ill = 1'b0; m_bus = 1'b0;
         end else model_step(mem_ready, opcode);
         @(posedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
